decode_issue_stage: RTL and testbench

- Sits directly upstream of the register-file/ALU datapath and drives its control inputs: op, addr_a, addr_b, addr_d, immed, y_sel and write.
- Accepts 32-bit instructions from fetch over a valid/ready handshake and buffers them in a 2-entry skid FIFO.
- Decodes R-type and I-type ALU instructions.
- Holds back any instruction with a read-after-write hazard against writes still in flight. Decoded results are presented in a registered output slot with its own valid/ready handshake.

---
 rtl/decode_issue_stage.sv | 143 ++++++++++++++
 tb/tb_decode_issue_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: 2-entry skid FIFO, R/I-type ALU decode, RAW hazard hold-back
// against in-flight writes, and a registered output slot with valid/ready.
module decode_issue_stage #(
  parameter int WB_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [6:0]       op,
  output logic [4:0]       addr_a,
  output logic [4:0]       addr_b,
  output logic [4:0]       addr_d,
  output logic [31:0]      immed,
  output logic             y_sel,
  output logic             write,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic [31:0] fifo_q [2];
  logic        wr_ptr, rd_ptr;
  logic [1:0]  count;
  logic [31:0] head;

  // Stage 0 of the write-back window is the accepting cycle itself, which the
  // output-slot compare covers; registered stages 1..WB_LAT-1 cover the rest.
  logic [WB_LAT-1:1] sb_vld;
  logic [4:0]        sb_rd [WB_LAT-1:1];

  logic        is_r, is_i, use_a, use_b;
  logic [4:0]  rs1, rs2, rd;
  logic        hit_a, hit_b, blocked;
  logic        push, issue, accept;

  assign head     = fifo_q[rd_ptr];
  assign in_ready = (count < 2'd2);
  assign push     = in_valid & in_ready & ~flush;
  assign accept   = out_valid & out_ready & write;

  assign rs1   = head[19:15];
  assign rs2   = head[24:20];
  assign rd    = head[11:7];
  assign is_r  = (head[6:0] == OPC_R);
  assign is_i  = (head[6:0] == OPC_I);
  assign use_a = is_r | is_i;
  assign use_b = is_r;

  always_comb begin
    hit_a = out_valid & write & (addr_d == rs1);
    hit_b = out_valid & write & (addr_d == rs2);
    for (int i = 1; i < WB_LAT; i++) begin
      hit_a = hit_a | (sb_vld[i] & (sb_rd[i] == rs1));
      hit_b = hit_b | (sb_vld[i] & (sb_rd[i] == rs2));
    end
    blocked = (use_a & (rs1 != 5'd0) & hit_a) | (use_b & (rs2 != 5'd0) & hit_b);
  end

  assign issue = (count != 2'd0) & ~blocked & (~out_valid | out_ready) & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= in_instr;
        wr_ptr         <= ~wr_ptr;
      end
      if (issue) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(issue);
    end
  end

  // Scoreboard keeps shifting through flush so accepted writes stay tracked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_vld <= '0;
      for (int i = 1; i < WB_LAT; i++) sb_rd[i] <= '0;
    end else begin
      sb_vld[1] <= accept;
      sb_rd[1]  <= accept ? addr_d : 5'd0;
      for (int i = 2; i < WB_LAT; i++) begin
        sb_vld[i] <= sb_vld[i-1];
        sb_rd[i]  <= sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      write     <= 1'b0;
      illegal   <= 1'b0;
      y_sel     <= 1'b0;
      op        <= '0;
      addr_a    <= '0;
      addr_b    <= '0;
      addr_d    <= '0;
      immed     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      write     <= 1'b0;
      illegal   <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      op        <= {head[30], head[14:12], head[6:4]};
      addr_a    <= rs1;
      addr_b    <= is_r ? rs2 : 5'd0;
      addr_d    <= rd;
      immed     <= is_i ? {{20{head[31]}}, head[31:20]} : 32'd0;
      y_sel     <= is_r;
      write     <= (is_r | is_i) & (rd != 5'd0);
      illegal   <= ~(is_r | is_i);
    end else if (out_valid & out_ready) begin
      out_valid <= 1'b0;
      write     <= 1'b0;
      illegal   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if ((count != 2'd0) && blocked && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: hand-computed expectations checked by
// immediate assertions, one linear stimulus sequence.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_ready, out_valid;
  logic [31:0] in_instr, immed;
  logic [6:0]  op;
  logic [4:0]  addr_a, addr_b, addr_d;
  logic        y_sel, write, illegal;
  logic [15:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  decode_issue_stage #(.WB_LAT(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .op(op), .addr_a(addr_a), .addr_b(addr_b),
    .addr_d(addr_d), .immed(immed), .y_sel(y_sel), .write(write),
    .illegal(illegal), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  localparam logic [31:0] ADD_1_2_3  = 32'h003100B3;
  localparam logic [31:0] ADDI_1_2_M = 32'hFFF10093;
  localparam logic [31:0] ADDI_5_0_7 = 32'h00700293;
  localparam logic [31:0] ADD_6_5_5  = 32'h00528333;
  localparam logic [31:0] ADDI_10    = 32'h00100513;
  localparam logic [31:0] ADDI_11    = 32'h00200593;
  localparam logic [31:0] ADDI_12    = 32'h00300613;
  localparam logic [31:0] ADDI_X0    = 32'h00100013;
  localparam logic [31:0] ADD_1_0_0  = 32'h000000B3;
  localparam logic [31:0] ILL        = 32'h00000073;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_write", write, 0);
    chk("rst_fields", {illegal, y_sel, op, addr_a, addr_b, addr_d}, 0);
    chk("rst_immed", immed, 0);
    chk("rst_stall", stall_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);

    // R-type issue
    out_ready = 1'b1; in_valid = 1'b1; in_instr = ADD_1_2_3;
    tick();
    chk("r_not_yet", out_valid, 0);
    in_instr = ADDI_1_2_M;
    tick();
    chk("r_valid", out_valid, 1);
    chk("r_addr", {addr_a, addr_b, addr_d}, {5'd2, 5'd3, 5'd1});
    chk("r_ysel_wr", {y_sel, write, illegal}, 3'b110);
    chk("r_immed", immed, 0);
    chk("r_op", op, 7'h03);

    // I-type sign extension
    in_valid = 1'b0;
    tick();
    chk("i_valid", out_valid, 1);
    chk("i_immed", immed, 32'hFFFFFFFF);
    chk("i_ysel_wr", {y_sel, write}, 2'b01);
    chk("i_addr_b", addr_b, 0);
    chk("i_op", op, 7'h41);
    tick();
    chk("i_drained", out_valid, 0);
    chk("i_no_stall", stall_cnt, 0);

    // RAW stall
    in_valid = 1'b1; in_instr = ADDI_5_0_7;
    tick();
    in_instr = ADD_6_5_5;
    tick();
    in_valid = 1'b0;
    chk("raw_first", {out_valid, 3'b0, addr_d}, {1'b1, 3'b0, 5'd5});
    tick();
    chk("raw_hold1", out_valid, 0);
    tick();
    chk("raw_hold2", out_valid, 0);
    tick();
    chk("raw_second", {out_valid, addr_a, addr_b, addr_d}, {1'b1, 5'd5, 5'd5, 5'd6});
    chk("raw_stall_cnt", stall_cnt, 2);
    tick();
    chk("raw_drained", out_valid, 0);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI_10;
    tick();
    in_instr = ADDI_11;
    tick();
    in_instr = ADDI_12;
    tick();
    in_valid = 1'b0;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_slot", {out_valid, 3'b0, addr_d}, {1'b1, 3'b0, 5'd10});
    tick(); tick();
    chk("bp_hold_d", addr_d, 10);
    chk("bp_hold_imm", immed, 1);
    chk("bp_hold_v", out_valid, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_second", {out_valid, 3'b0, addr_d}, {1'b1, 3'b0, 5'd11});
    chk("bp_ready_back", in_ready, 1);
    tick();
    chk("bp_third", {out_valid, 3'b0, addr_d}, {1'b1, 3'b0, 5'd12});
    chk("bp_third_imm", immed, 3);
    tick();
    chk("bp_drained", out_valid, 0);

    // Flush with two buffered
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI_10;
    tick();
    in_instr = ADDI_11;
    tick();
    in_instr = ADDI_12;
    tick();
    flush = 1'b1; in_instr = ADDI_10;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_write", write, 0);
    chk("fl_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick(); tick();
    chk("fl_no_issue", out_valid, 0);
    // Push coinciding with flush on an empty FIFO is dropped
    flush = 1'b1; in_valid = 1'b1; in_instr = ADDI_11;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("fl_push_dropped", out_valid, 0);

    // x0 handling
    in_valid = 1'b1; in_instr = ADDI_X0;
    tick();
    in_instr = ADD_1_0_0;
    tick();
    in_valid = 1'b0;
    chk("x0_first", {out_valid, write, 3'b0, addr_d}, {2'b10, 3'b0, 5'd0});
    tick();
    chk("x0_second", {out_valid, write, 3'b0, addr_d}, {2'b11, 3'b0, 5'd1});
    chk("x0_no_stall", stall_cnt, 2);
    tick();

    // Illegal opcode
    in_valid = 1'b1; in_instr = ILL;
    tick();
    in_instr = ADD_1_2_3;
    tick();
    in_valid = 1'b0;
    chk("ill_flags", {out_valid, illegal, write, y_sel}, 4'b1100);
    tick();
    chk("ill_next", {out_valid, illegal, write, y_sel}, 4'b1011);
    chk("ill_next_addr", {addr_a, addr_b, addr_d}, {5'd2, 5'd3, 5'd1});
    tick();

    // Asynchronous reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_instr = ADDI_10;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar_pre", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_fields", {write, addr_d}, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
